// File: rtl/pll_ce_gen.sv
// pll_ce_gen: lock-gated multi-channel fractional clock-enable generator (rate refclk*inc/mod).
// Define CE_ALIGN_EN to add the align port that clears every accumulator in RUN.
module pll_ce_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 24,
  parameter int LOCK_CYCLES = 1024,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(LOCK_CYCLES)
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_mod,
`ifdef CE_ALIGN_EN
  input  logic              align,
`endif
  output logic [NUM_CH-1:0] ce,
  output logic              ready
);
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;
  state_t state;
  logic sync1, lk, run, clr;
  logic [CNT_W-1:0] cnt;
  assign run = state == RUN && lk;
`ifdef CE_ALIGN_EN
  assign clr = !run || align;
`else
  assign clr = !run;
`endif
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
      state <= WAIT_LOCK;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
      unique case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (lk) state <= SETTLE;
        end
        SETTLE: begin
          if (!lk) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            state <= RUN;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state <= WAIT_LOCK;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          ready <= 1'b0;
        end
      endcase
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] acc, inc, mod;
    logic [ACC_W:0] s;
    logic wr, hit, ce_q;
    assign wr  = cfg_we && cfg_ch == CH_W'(g);
    assign s   = {1'b0, acc} + {1'b0, inc};
    assign hit = s >= {1'b0, mod};
    assign ce[g] = ce_q;
    // inc>=mod saturates to a strobe every cycle while keeping acc at 0
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        acc  <= '0;
        inc  <= '0;
        mod  <= '0;
        ce_q <= 1'b0;
      end else if (wr) begin
        inc  <= cfg_inc;
        mod  <= cfg_mod;
        acc  <= '0;
        ce_q <= 1'b0;
      end else begin
        acc  <= (clr || mod == '0 || inc >= mod) ? '0 : hit ? ACC_W'(s - {1'b0, mod}) : s[ACC_W-1:0];
        ce_q <= !clr && mod != '0 && (inc >= mod || hit);
      end
    end
  end
endmodule

// File: tb/tb_pll_ce_gen.sv
// tb_pll_ce_gen: randomized bench for pll_ce_gen against a closed-form rate model.
// The model tracks lock as a streak of synced-locked cycles and pulses as floor((k+1)*inc/mod) steps.
module tb_pll_ce_gen;
  localparam int NUM_CH = 5;
  localparam int ACC_W = 24;
  localparam int L = 8;
  localparam int CH_W = $clog2(NUM_CH);
  logic refclk = 1'b0;
  logic rst_n, pll_locked, cfg_we, align, ready;
  logic [CH_W-1:0] cfg_ch;
  logic [ACC_W-1:0] cfg_inc, cfg_mod;
  logic [NUM_CH-1:0] ce;
  int n_vec = 0, n_err = 0;
  bit p1, p2;
  int streak;
  longint m_inc[NUM_CH], m_mod[NUM_CH], m_k[NUM_CH];
  logic [NUM_CH-1:0] exp_ce;
  logic exp_rdy;
  always #5 refclk = ~refclk;
  pll_ce_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(L)) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc),
    .cfg_mod(cfg_mod),
`ifdef CE_ALIGN_EN
    .align(align),
`endif
    .ce(ce),
    .ready(ready)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle();
    bit lk_seen, run, al;
    @(posedge refclk);
    lk_seen = p2;
    p2 = p1;
    p1 = pll_locked;
    streak = lk_seen ? (streak < 1000000 ? streak + 1 : streak) : 0;
    run = streak >= L + 2;
    al = 1'b0;
`ifdef CE_ALIGN_EN
    al = run && align;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        m_inc[i] = longint'(cfg_inc);
        m_mod[i] = longint'(cfg_mod);
        m_k[i] = 0;
        exp_ce[i] = 1'b0;
      end else if (!run || al) begin
        m_k[i] = 0;
        exp_ce[i] = 1'b0;
      end else if (m_mod[i] == 0) begin
        exp_ce[i] = 1'b0;
      end else if (m_inc[i] >= m_mod[i]) begin
        exp_ce[i] = 1'b1;
      end else begin
        exp_ce[i] = ((m_k[i] + 1) * m_inc[i] / m_mod[i]) != (m_k[i] * m_inc[i] / m_mod[i]);
        m_k[i]++;
      end
    end
    exp_rdy = streak >= L + 1;
    @(negedge refclk);
    chk("ready", longint'(ready), longint'(exp_rdy));
    chk("ce", longint'(ce), longint'(exp_ce));
  endtask
  initial begin
    int wr_inc[5] = '{1, 2, 5, 7, 3};
    int wr_mod[5] = '{3, 5, 0, 7, 10};
    int cnt[NUM_CH];
    int first_rdy, first_low, last_low, k;
    rst_n = 1'b0;
    pll_locked = 1'b1;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_inc = '0;
    cfg_mod = '0;
    align = 1'b0;
    p1 = 1'b0;
    p2 = 1'b0;
    streak = 0;
    exp_ce = '0;
    exp_rdy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_inc[i] = 0;
      m_mod[i] = 0;
      m_k[i] = 0;
      cnt[i] = 0;
    end
    repeat (3) @(negedge refclk);
    chk("rst_ready", longint'(ready), 0);
    chk("rst_ce", longint'(ce), 0);
    rst_n = 1'b1;
    first_rdy = 0;
    for (int c = 1; c <= 11; c++) begin
      cfg_we = c <= 5;
      if (c <= 5) begin
        cfg_ch = CH_W'(c - 1);
        cfg_inc = ACC_W'(wr_inc[c-1]);
        cfg_mod = ACC_W'(wr_mod[c-1]);
      end
      cycle();
      if (ready && first_rdy == 0) first_rdy = c;
    end
    cfg_we = 1'b0;
    chk("ready_lat", first_rdy, 11);
    for (int n = 0; n < 1000; n++) begin
      cycle();
      for (int i = 0; i < NUM_CH; i++) cnt[i] += int'(ce[i]);
    end
    chk("cnt_ch0", cnt[0], 333);
    chk("cnt_ch1", cnt[1], 400);
    chk("cnt_ch2", cnt[2], 0);
    chk("cnt_ch3", cnt[3], 1000);
    chk("cnt_ch4", cnt[4], 300);
    k = 0;
    while (!ce[0] && k < 10) begin
      cycle();
      k++;
    end
    chk("ch0_seen", longint'(ce[0]), 1);
    cycle();
    cycle();
    cfg_we = 1'b1;
    cfg_ch = 0;
    cfg_inc = 1;
    cfg_mod = 3;
    cycle();
    chk("due_wr", longint'(ce[0]), 0);
    cfg_ch = CH_W'(NUM_CH);
    cfg_inc = 1;
    cfg_mod = 1;
    cycle();
    cfg_we = 1'b0;
    repeat (20) cycle();
    pll_locked = 1'b0;
    cycle();
    pll_locked = 1'b1;
    first_low = 0;
    last_low = 0;
    for (int j = 1; j <= 40; j++) begin
      cycle();
      if (!ready) begin
        last_low = j;
        if (first_low == 0) first_low = j;
      end
    end
    chk("drop_fall", first_low, 2);
    chk("relock", last_low, 10);
    for (int n = 0; n < 3000; n++) begin
      pll_locked = $urandom_range(0, 299) != 0;
      cfg_we = $urandom_range(0, 19) == 0;
      cfg_ch = CH_W'($urandom_range(0, 7));
      cfg_mod = ($urandom_range(0, 9) == 0) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 12));
      cfg_inc = ($urandom_range(0, 9) == 0) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 14));
      align = $urandom_range(0, 49) == 0;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
